// File: rtl/vt52_pkg.sv
// -----------------------------------------------------------------------------
// vt52_pkg
// Shared definitions for the VT52 escape-sequence parser:
//   cmd_op_t        - command opcode driven on cmd_op (4 bits, OP_NOP = 0)
//   parser_state_t  - parser FSM state (GROUND, ESC, Y_ROW, Y_COL)
//   ESC_CHAR        - escape byte 0x1B
//   ADDR_OFFSET     - bias added to row/column bytes of ESC Y (0x20)
//   addr_clamp()    - removes the address bias and saturates at a limit
// -----------------------------------------------------------------------------
package vt52_pkg;

    typedef enum logic [3:0] {
        OP_NOP       = 4'd0,
        OP_CHAR      = 4'd1,
        OP_CR        = 4'd2,
        OP_LF        = 4'd3,
        OP_BS        = 4'd4,
        OP_TAB       = 4'd5,
        OP_UP        = 4'd6,
        OP_DOWN      = 4'd7,
        OP_RIGHT     = 4'd8,
        OP_LEFT      = 4'd9,
        OP_HOME      = 4'd10,
        OP_ERASE_EOS = 4'd11,
        OP_ERASE_EOL = 4'd12,
        OP_RLF       = 4'd13,
        OP_GOTO      = 4'd14,
        OP_IDENT     = 4'd15
    } cmd_op_t;

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_ESC    = 2'd1,
        ST_Y_ROW  = 2'd2,
        ST_Y_COL  = 2'd3
    } parser_state_t;

    localparam logic [7:0] ESC_CHAR    = 8'h1B;
    localparam logic [7:0] ADDR_OFFSET = 8'h20;

    // The whole subtract/compare is done on 8 bits; callers truncate the
    // result to the narrow field only after it has been saturated, so an
    // out-of-range byte can never wrap into a small coordinate.
    function automatic logic [7:0] addr_clamp(input logic [7:0] b,
                                              input logic [7:0] lim);
        logic [7:0] d;
        d = b - ADDR_OFFSET;
        return (d > lim) ? lim : d;
    endfunction

endpackage

// File: rtl/vt52_byte_classify.sv
// -----------------------------------------------------------------------------
// vt52_byte_classify
// Purely combinational decode of one input byte in the current parser state.
// Optional feature: define VT52_IDENT_EN to decode ESC 'Z' as OP_IDENT;
// without it ESC 'Z' is treated like any unknown final byte.
// Ports:
//   state_i      - current parser state
//   byte_i       - byte being offered
//   next_state_o - state to enter if the byte is accepted
//   op_o         - command completed by this byte (OP_NOP = none)
//   row_latch_o  - byte is the row coordinate of ESC Y and must be stored
// -----------------------------------------------------------------------------
module vt52_byte_classify
    import vt52_pkg::*;
(
    input  parser_state_t state_i,
    input  logic [7:0]    byte_i,
    output parser_state_t next_state_o,
    output cmd_op_t       op_o,
    output logic          row_latch_o
);

    always_comb begin
        next_state_o = state_i;
        op_o         = OP_NOP;
        row_latch_o  = 1'b0;

        case (state_i)
            ST_GROUND: begin
                if (byte_i >= 8'h20 && byte_i <= 8'h7E) begin
                    op_o = OP_CHAR;
                end else begin
                    case (byte_i)
                        8'h0D:    op_o = OP_CR;
                        8'h0A:    op_o = OP_LF;
                        8'h08:    op_o = OP_BS;
                        8'h09:    op_o = OP_TAB;
                        ESC_CHAR: next_state_o = ST_ESC;
                        default:  ; // DEL, C0 leftovers and 8-bit bytes vanish
                    endcase
                end
            end

            ST_ESC: begin
                // Every final returns to GROUND except ESC Y and a repeated ESC.
                next_state_o = ST_GROUND;
                case (byte_i)
                    8'h41:    op_o = OP_UP;         // 'A'
                    8'h42:    op_o = OP_DOWN;       // 'B'
                    8'h43:    op_o = OP_RIGHT;      // 'C'
                    8'h44:    op_o = OP_LEFT;       // 'D'
                    8'h48:    op_o = OP_HOME;       // 'H'
                    8'h4A:    op_o = OP_ERASE_EOS;  // 'J'
                    8'h4B:    op_o = OP_ERASE_EOL;  // 'K'
                    8'h49:    op_o = OP_RLF;        // 'I'
                    8'h59:    next_state_o = ST_Y_ROW;  // 'Y'
                    ESC_CHAR: next_state_o = ST_ESC;    // ESC ESC restarts
`ifdef VT52_IDENT_EN
                    8'h5A:    op_o = OP_IDENT;      // 'Z'
`endif
                    default:  ;
                endcase
            end

            ST_Y_ROW: begin
                // A control byte inside ESC Y aborts the whole sequence.
                if (byte_i >= ADDR_OFFSET) begin
                    next_state_o = ST_Y_COL;
                    row_latch_o  = 1'b1;
                end else begin
                    next_state_o = ST_GROUND;
                end
            end

            ST_Y_COL: begin
                next_state_o = ST_GROUND;
                if (byte_i >= ADDR_OFFSET) begin
                    op_o = OP_GOTO;
                end
            end

            default: next_state_o = ST_GROUND;
        endcase
    end

endmodule

// File: rtl/vt52_escape_parser.sv
// -----------------------------------------------------------------------------
// vt52_escape_parser
// Turns a VT52 byte stream into screen commands, one command buffered at a
// time. Optional feature: define VT52_IDENT_EN to decode ESC 'Z' (OP_IDENT).
//
// Handshake: an input byte transfers on a rising edge where in_valid and
// in_ready are both high; a command transfers on a rising edge where cmd_valid
// and cmd_ready are both high. in_ready is simply !cmd_valid, so a held
// command stalls the input, and cmd_* stay stable while cmd_valid is high.
//
// Parameters: ROWS (<= 32) and COLS (<= 128) set the GOTO clamp limits.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   in_data/in_valid/in_ready
//                         - byte stream input
//   cmd_op/cmd_char/cmd_row/cmd_col/cmd_valid/cmd_ready
//                         - command output; unused fields read as zero
//   dbg_state             - current parser state (parser_state_t encoding)
// -----------------------------------------------------------------------------
module vt52_escape_parser
    import vt52_pkg::*;
#(
    parameter int ROWS = 24,
    parameter int COLS = 80
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] cmd_op,
    output logic [7:0] cmd_char,
    output logic [4:0] cmd_row,
    output logic [6:0] cmd_col,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [1:0] dbg_state
);

    localparam logic [7:0] ROW_MAX = 8'(ROWS - 1);
    localparam logic [7:0] COL_MAX = 8'(COLS - 1);

    parser_state_t state_q, state_d;
    logic [4:0]    row_q, row_d;          // row captured between ESC Y r and c
    logic          cmd_valid_q, cmd_valid_d;
    cmd_op_t       cmd_op_q, cmd_op_d;
    logic [7:0]    cmd_char_q, cmd_char_d;
    logic [4:0]    cmd_row_q, cmd_row_d;
    logic [6:0]    cmd_col_q, cmd_col_d;

    parser_state_t cls_next_state;
    cmd_op_t       cls_op;
    logic          cls_row_latch;
    logic          accept;

    vt52_byte_classify u_classify (
        .state_i      (state_q),
        .byte_i       (in_data),
        .next_state_o (cls_next_state),
        .op_o         (cls_op),
        .row_latch_o  (cls_row_latch)
    );

    assign accept = in_valid && !cmd_valid_q;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        cmd_valid_d = cmd_valid_q;
        cmd_op_d    = cmd_op_q;
        cmd_char_d  = cmd_char_q;
        cmd_row_d   = cmd_row_q;
        cmd_col_d   = cmd_col_q;

        if (accept) begin
            // accept implies no command is pending, so loading a new command
            // never collides with the output handshake below.
            state_d = cls_next_state;
            if (cls_row_latch) begin
                row_d = 5'(addr_clamp(in_data, ROW_MAX));
            end
            if (cls_op != OP_NOP) begin
                cmd_valid_d = 1'b1;
                cmd_op_d    = cls_op;
                cmd_char_d  = (cls_op == OP_CHAR) ? in_data : 8'h00;
                cmd_row_d   = (cls_op == OP_GOTO) ? row_q : 5'd0;
                cmd_col_d   = (cls_op == OP_GOTO) ? 7'(addr_clamp(in_data, COL_MAX)) : 7'd0;
            end
        end else if (cmd_valid_q && cmd_ready) begin
            // Fields are left as they were; only cmd_valid marks them stale.
            cmd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_GROUND;
            row_q       <= 5'd0;
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= OP_NOP;
            cmd_char_q  <= 8'h00;
            cmd_row_q   <= 5'd0;
            cmd_col_q   <= 7'd0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_op_q    <= cmd_op_d;
            cmd_char_q  <= cmd_char_d;
            cmd_row_q   <= cmd_row_d;
            cmd_col_q   <= cmd_col_d;
        end
    end

    assign in_ready  = !cmd_valid_q;
    assign cmd_valid = cmd_valid_q;
    assign cmd_op    = cmd_op_q;
    assign cmd_char  = cmd_char_q;
    assign cmd_row   = cmd_row_q;
    assign cmd_col   = cmd_col_q;
    assign dbg_state = state_q;

endmodule
